// File: rtl/ingress_arbiter.sv
// Ingress switching stage: per-output round-robin arbitration across 8 input
// deserialisers, FIFO push generation, input acknowledge and bad-address drop.
module ingress_arbiter #(
  parameter int PAYLOAD_W  = 32,
  parameter int ADDR_W     = 4,
  parameter int DROP_CNT_W = 16
) (
  input  logic                    clock_ingress,
  input  logic                    reset_n,
  input  logic [7:0]              vld_in,
  input  logic [8*ADDR_W-1:0]     addr_in,
  input  logic [8*PAYLOAD_W-1:0]  payload_in,
  input  logic [7:0]              fifo_full,
  output logic [7:0]              clr_out,
  output logic [7:0]              push_n,
  output logic [8*PAYLOAD_W-1:0]  data_out,
  output logic [8*3-1:0]          grant_src,
  output logic [DROP_CNT_W-1:0]   drop_count
);

  localparam int N = 8;

  logic [N-1:0]          eligible;
  logic [N-1:0]          bad;
  logic [2:0]            dest      [N];
  logic [N-1:0]          req       [N];
  logic [2:0]            ptr       [N];
  logic [N-1:0]          win_vld;
  logic [2:0]            win_idx   [N];
  logic [PAYLOAD_W-1:0]  win_pay   [N];
  logic [N-1:0]          clr_next;
  logic [3:0]            bad_cnt;
  logic [DROP_CNT_W:0]   drop_sum;
  logic [DROP_CNT_W-1:0] drop_next;

  // Decode each input: the clr mask blocks re-granting a packet whose vld is
  // still high in the cycle right after its acknowledge.
  always_comb begin : decode
    logic [ADDR_W-1:0] a;
    a = '0;
    for (int unsigned i = 0; i < N; i++) begin
      a           = addr_in[i*ADDR_W +: ADDR_W];
      eligible[i] = vld_in[i] & ~clr_out[i];
      bad[i]      = eligible[i] & ((a >> 3) != '0);
      dest[i]     = a[2:0];
    end
  end

  always_comb begin
    for (int unsigned j = 0; j < N; j++) begin
      for (int unsigned i = 0; i < N; i++) begin
        req[j][i] = eligible[i] & ~bad[i] & (dest[i] == 3'(j));
      end
    end
  end

  // Round-robin search from ptr[j]; 3-bit addition supplies the modulo-8 wrap.
  always_comb begin : arbitrate
    logic [2:0] idx;
    idx = '0;
    for (int unsigned j = 0; j < N; j++) begin
      win_vld[j] = 1'b0;
      win_idx[j] = '0;
      if (!fifo_full[j]) begin
        for (int unsigned k = 0; k < N; k++) begin
          idx = ptr[j] + 3'(k);
          if (!win_vld[j] && req[j][idx]) begin
            win_vld[j] = 1'b1;
            win_idx[j] = idx;
          end
        end
      end
    end
  end

  always_comb begin
    for (int unsigned j = 0; j < N; j++) begin
      win_pay[j] = '0;
      for (int unsigned i = 0; i < N; i++) begin
        if (win_idx[j] == 3'(i)) win_pay[j] = payload_in[i*PAYLOAD_W +: PAYLOAD_W];
      end
    end
  end

  always_comb begin
    clr_next = bad;
    bad_cnt  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      bad_cnt = bad_cnt + 4'(bad[i]);
    end
    for (int unsigned j = 0; j < N; j++) begin
      if (win_vld[j]) clr_next[win_idx[j]] = 1'b1;
    end
    drop_sum  = {1'b0, drop_count} + (DROP_CNT_W+1)'(bad_cnt);
    drop_next = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
  end

  always_ff @(posedge clock_ingress or negedge reset_n) begin
    if (!reset_n) begin
      clr_out    <= '0;
      push_n     <= '1;
      data_out   <= '0;
      grant_src  <= '0;
      drop_count <= '0;
      for (int unsigned j = 0; j < N; j++) ptr[j] <= '0;
    end else begin
      clr_out    <= clr_next;
      drop_count <= drop_next;
      for (int unsigned j = 0; j < N; j++) begin
        push_n[j] <= ~win_vld[j];
        if (win_vld[j]) begin
          data_out[j*PAYLOAD_W +: PAYLOAD_W] <= win_pay[j];
          grant_src[j*3 +: 3]                <= win_idx[j];
          ptr[j]                             <= win_idx[j] + 3'd1;
        end
      end
    end
  end

endmodule
